// File: rtl/pattern_deadtime.sv
// Break-before-make output stage for the step-pattern sequencer.
// Latency: pure turn-off changes appear one edge after sampling. Turn-on bits appear DEAD_CYCLES edges after the
// turn-off bits have dropped. No input backpressure: a new pattern is accepted on any edge and retargets a dead interval.
module pattern_deadtime #(
  parameter int WIDTH       = 8,
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     pat_in,
  output logic [WIDTH-1:0]     pat_out,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] trans_cnt
);

  typedef enum logic {IDLE, DEAD} state_t;

  // Timer counts the remaining edges of the dead interval down to zero.
  // With no dead time configured, the reload value is unused.
  localparam bit         HAS_DEAD = (DEAD_CYCLES > 0);
  localparam logic [7:0] RELOAD   = HAS_DEAD ? 8'(DEAD_CYCLES - 1) : 8'd0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target, target_nxt;
  logic [WIDTH-1:0] pat_nxt;
  logic [7:0]       timer, timer_nxt;
  logic             count_nxt;
  logic             change;
  logic             new_on;

  // A change is any difference from the committed target. New-on bits are
  // those requested high that the drivers are not already driving.
  assign change = (pat_in != target);
  assign new_on = |(pat_in & ~pat_out);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-datapath logic.
  // Retargets are handled identically in both states. Off bits drop at once.
  // Any remaining new-on bits (re)start the dead interval.
  always_comb begin
    state_nxt  = state;
    pat_nxt    = pat_out;
    target_nxt = target;
    timer_nxt  = timer;
    count_nxt  = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      pat_nxt    = '0;
      target_nxt = '0;
      timer_nxt  = 8'd0;
    end else if (change) begin
      target_nxt = pat_in;
      if (new_on && HAS_DEAD) begin
        pat_nxt   = pat_out & pat_in;
        timer_nxt = RELOAD;
        state_nxt = DEAD;
      end else begin
        pat_nxt   = pat_in;
        timer_nxt = 8'd0;
        state_nxt = IDLE;
        count_nxt = 1'b1;
      end
    end else begin
      case (state)
        DEAD: begin
          if (timer == 8'd0) begin
            pat_nxt   = target;
            state_nxt = IDLE;
            count_nxt = 1'b1;
          end else begin
            timer_nxt = timer - 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode: busy comes straight off the state flop.
  always_comb begin
    busy = (state == DEAD);
  end

  // Datapath registers. The transition counter saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_out   <= '0;
      target    <= '0;
      timer     <= 8'd0;
      trans_cnt <= '0;
    end else begin
      pat_out <= pat_nxt;
      target  <= target_nxt;
      timer   <= timer_nxt;
      if (count_nxt && (trans_cnt != {CNT_WIDTH{1'b1}})) begin
        trans_cnt <= trans_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pattern_deadtime.sv
// Directed bench for pattern_deadtime: default dead time, saturating counter, zero dead time.
module tb_pattern_deadtime;

  logic clk = 1'b0;
  logic reset;

  // Main instance: DEAD_CYCLES = 4, CNT_WIDTH = 16
  logic        en, m_busy;
  logic [7:0]  pin, pout;
  logic [15:0] cnt;
  // Saturation instance: CNT_WIDTH = 2
  logic        s_en, s_busy;
  logic [7:0]  s_pin, s_pout;
  logic [1:0]  s_cnt;
  // Zero dead-time instance
  logic        z_en, z_busy;
  logic [7:0]  z_pin, z_pout;
  logic [15:0] z_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] seq [6];
  logic [7:0] zprev;

  always #5 clk = ~clk;

  pattern_deadtime #(.WIDTH(8), .DEAD_CYCLES(4), .CNT_WIDTH(16)) u_main (
    .clk(clk), .reset(reset), .enable(en), .pat_in(pin),
    .pat_out(pout), .busy(m_busy), .trans_cnt(cnt));

  pattern_deadtime #(.WIDTH(8), .DEAD_CYCLES(4), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .enable(s_en), .pat_in(s_pin),
    .pat_out(s_pout), .busy(s_busy), .trans_cnt(s_cnt));

  pattern_deadtime #(.WIDTH(8), .DEAD_CYCLES(0), .CNT_WIDTH(16)) u_zero (
    .clk(clk), .reset(reset), .enable(z_en), .pat_in(z_pin),
    .pat_out(z_pout), .busy(z_busy), .trans_cnt(z_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit later. Any bit of the main
  // instance rising must coincide with the end of a dead interval.
  task automatic tick();
    logic [7:0] prev_p;
    logic       prev_b;
    prev_p = pout;
    prev_b = m_busy;
    @(posedge clk);
    #1;
    if ((pout & ~prev_p) != 8'h00)
      chk("no_early_on", {31'b0, prev_b & ~m_busy}, 32'd1);
  endtask

  // Four edges of the intermediate pattern with busy high, then the final one.
  task automatic dead_window(input string tag, input logic [7:0] mid,
                             input logic [7:0] fin, input logic [15:0] exp_cnt);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_mid_pat"}, pout, mid);
      chk({tag, "_mid_busy"}, m_busy, 1);
    end
    tick();
    chk({tag, "_fin_pat"}, pout, fin);
    chk({tag, "_fin_busy"}, m_busy, 0);
    chk({tag, "_fin_cnt"}, cnt, exp_cnt);
  endtask

  initial begin
    seq = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};
    reset = 1'b1;
    en = 1'b0;   pin = 8'h00;
    s_en = 1'b0; s_pin = 8'h00;
    z_en = 1'b0; z_pin = 8'h00;
    #1;
    chk("rst_pat", pout, 8'h00);
    chk("rst_busy", m_busy, 0);
    chk("rst_cnt", cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // First enable: every bit is new-on, full dead time from 0x00
    en = 1'b1; pin = 8'h90;
    dead_window("first", 8'h00, 8'h90, 16'd1);

    // 0x90 -> 0x18: bit 7 drops at once, bit 3 waits
    pin = 8'h18;
    dead_window("overlap", 8'h10, 8'h18, 16'd2);

    // Pure turn-off applies on the next edge
    pin = 8'h08;
    tick();
    chk("off_pat", pout, 8'h08);
    chk("off_busy", m_busy, 0);
    chk("off_cnt", cnt, 16'd3);

    // Reach 0x48 for the retarget case
    pin = 8'h48;
    dead_window("to48", 8'h08, 8'h48, 16'd4);

    // Retarget two edges into a dead interval: timer restarts, one count
    pin = 8'h60;
    tick();
    chk("rt_a_pat", pout, 8'h40);
    chk("rt_a_busy", m_busy, 1);
    tick();
    chk("rt_b_pat", pout, 8'h40);
    chk("rt_b_busy", m_busy, 1);
    pin = 8'h24;
    dead_window("retarget", 8'h00, 8'h24, 16'd5);

    // Enable drop mid-dead aborts without counting
    pin = 8'h26;
    tick();
    chk("ab_dead_pat", pout, 8'h24);
    chk("ab_dead_busy", m_busy, 1);
    en = 1'b0;
    tick();
    chk("ab_pat", pout, 8'h00);
    chk("ab_busy", m_busy, 0);
    chk("ab_cnt", cnt, 16'd5);
    repeat (5) tick();
    chk("ab_hold_cnt", cnt, 16'd5);
    chk("ab_hold_pat", pout, 8'h00);

    // Re-enable: full dead time from zero
    en = 1'b1;
    dead_window("reen", 8'h00, 8'h26, 16'd6);

    // Asynchronous reset between edges, mid-dead
    pin = 8'h03;
    tick();
    chk("ar_dead_pat", pout, 8'h02);
    chk("ar_dead_busy", m_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_pat", pout, 8'h00);
    chk("ar_busy", m_busy, 0);
    chk("ar_cnt", cnt, 16'd0);
    reset = 1'b0;
    tick();
    chk("ar_after_pat", pout, 8'h00);
    chk("ar_after_busy", m_busy, 1);
    chk("ar_after_cnt", cnt, 16'd0);

    // Saturating 2-bit counter over the six-step sequence
    s_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_pin = seq[i];
      repeat (6) tick();
      chk("sat_pat", s_pout, seq[i]);
      chk("sat_cnt", s_cnt, (i < 3) ? i + 1 : 3);
    end

    // Zero dead time: one-edge latency, busy never high
    z_en = 1'b1;
    zprev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      z_pin = seq[i];
      chk("zero_hold", z_pout, zprev);
      tick();
      chk("zero_pat", z_pout, seq[i]);
      chk("zero_busy", z_busy, 0);
      zprev = seq[i];
    end
    chk("zero_cnt", z_cnt, 16'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
